// File: rtl/irq_pkg.sv
// Shared register offsets, timer control bit positions and the byte-enable
// merge used by every byte-masked register in the interrupt controller.
package irq_pkg;

  localparam logic [5:0] OFF_PENDING  = 6'h00;
  localparam logic [5:0] OFF_ENABLE   = 6'h04;
  localparam logic [5:0] OFF_CLAIM    = 6'h08;
  localparam logic [5:0] OFF_COMPLETE = 6'h0C;
  localparam logic [5:0] OFF_TCNT     = 6'h10;
  localparam logic [5:0] OFF_TCMP     = 6'h14;
  localparam logic [5:0] OFF_TCTRL    = 6'h18;

  localparam int unsigned TCTRL_EN     = 0;
  localparam int unsigned TCTRL_RELOAD = 1;

  function automatic logic [31:0] byte_merge(input logic [31:0] cur,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = cur;
    for (int unsigned b = 0; b < 4; b++) begin
      if (be[b]) res[b*8 +: 8] = wdata[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/irq_timer.sv
// Compare timer: free-running count with optional reload on compare match.
// `match` is combinational so the parent latches it on the same edge.
module irq_timer
  import irq_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_tcnt,
  input  logic        wr_tcmp,
  input  logic        wr_tctrl,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic [31:0] tcnt,
  output logic [31:0] tcmp,
  output logic [1:0]  tctrl,
  output logic        match
);

  logic [31:0] tcnt_q, tcnt_d;
  logic [31:0] tcmp_q, tcmp_d;
  logic [1:0]  tctrl_q, tctrl_d;
  logic        en;
  logic        reload;

  assign en     = tctrl_q[TCTRL_EN];
  assign reload = tctrl_q[TCTRL_RELOAD];
  assign match  = en && (tcnt_q == tcmp_q);

  // Compare uses the pre-write count; a bus write overrides the increment.
  always_comb begin
    tcnt_d = tcnt_q;
    if (en) tcnt_d = (match && reload) ? '0 : tcnt_q + 32'd1;
    if (wr_tcnt) tcnt_d = byte_merge(tcnt_q, wdata, be);

    tcmp_d = tcmp_q;
    if (wr_tcmp) tcmp_d = byte_merge(tcmp_q, wdata, be);

    tctrl_d = tctrl_q;
    if (wr_tctrl && be[0]) tctrl_d = wdata[1:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tcnt_q  <= '0;
      tcmp_q  <= '0;
      tctrl_q <= '0;
    end else begin
      tcnt_q  <= tcnt_d;
      tcmp_q  <= tcmp_d;
      tctrl_q <= tctrl_d;
    end
  end

  assign tcnt  = tcnt_q;
  assign tcmp  = tcmp_q;
  assign tctrl = tctrl_q;

endmodule

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: edge-latched pending bits, enables,
// single-level claim/complete and a compare timer wired as source 0.
module irq_controller
  import irq_pkg::*;
#(
  parameter int unsigned N_SRC     = 8,
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] src_irq,
  input  logic [31:0]      bus_addr,
  input  logic [31:0]      bus_wdata,
  input  logic             bus_wr,
  input  logic [15:0]      bus_wr_mask,
  output logic             bus_sel,
  output logic [31:0]      bus_rdata,
  output logic             irq
);

  localparam int unsigned NP    = N_SRC + 1;
  localparam logic [31:0] VALID = 32'((64'd1 << NP) - 64'd1);

  logic [31:0]      pending_q, pending_d;
  logic [31:0]      enable_q, enable_d;
  logic [5:0]       active_q, active_d;
  logic [N_SRC-1:0] src_q, src_d;
  logic             irq_q, irq_d;

  logic [5:0]  off;
  logic [3:0]  be;
  logic        we;
  logic        claim_ok;
  logic [31:0] set_vec;
  logic [31:0] tcnt, tcmp;
  logic [1:0]  tctrl;
  logic        timer_match;
  logic [31:0] rdata;
  logic        unused_bits;

  assign unused_bits = ^{bus_addr[1:0], bus_wr_mask[15:4]};

  assign bus_sel  = (bus_addr[31:6] == BASE_ADDR[31:6]);
  assign off      = {bus_addr[5:2], 2'b00};
  assign be       = bus_wr_mask[3:0];
  assign we       = bus_wr && bus_sel;
  assign claim_ok = (bus_wdata != 32'd0) && (bus_wdata <= NP);

  function automatic logic [5:0] claim_id(input logic [31:0] req);
    logic [5:0] id;
    id = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (req[i] && id == '0) id = 6'(i + 1);
    end
    return id;
  endfunction

  irq_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .wr_tcnt  (we && off == OFF_TCNT),
    .wr_tcmp  (we && off == OFF_TCMP),
    .wr_tctrl (we && off == OFF_TCTRL),
    .wdata    (bus_wdata),
    .be       (be),
    .tcnt     (tcnt),
    .tcmp     (tcmp),
    .tctrl    (tctrl),
    .match    (timer_match)
  );

  // New edges are ORed in after both clear paths so a same-cycle set wins.
  always_comb begin
    set_vec = 32'({src_irq & ~src_q, timer_match});

    pending_d = pending_q;
    if (we && off == OFF_PENDING)
      pending_d = pending_q & ~byte_merge('0, bus_wdata, be);
    if (we && off == OFF_CLAIM && claim_ok)
      pending_d = pending_d & ~(32'd1 << (bus_wdata - 32'd1));
    pending_d = (pending_d | set_vec) & VALID;

    enable_d = enable_q;
    if (we && off == OFF_ENABLE)
      enable_d = byte_merge(enable_q, bus_wdata, be) & VALID;

    active_d = active_q;
    if (we && off == OFF_CLAIM && claim_ok) active_d = bus_wdata[5:0];
    if (we && off == OFF_COMPLETE)          active_d = '0;

    src_d = src_irq;
    irq_d = (|(pending_q & enable_q)) && (active_q == '0);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pending_q <= '0;
      enable_q  <= '0;
      active_q  <= '0;
      src_q     <= '0;
      irq_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      enable_q  <= enable_d;
      active_q  <= active_d;
      src_q     <= src_d;
      irq_q     <= irq_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (bus_sel) begin
      case (off)
        OFF_PENDING:  rdata = pending_q;
        OFF_ENABLE:   rdata = enable_q;
        OFF_CLAIM:    rdata = {26'b0, claim_id(pending_q & enable_q)};
        OFF_COMPLETE: rdata = {26'b0, active_q};
        OFF_TCNT:     rdata = tcnt;
        OFF_TCMP:     rdata = tcmp;
        OFF_TCTRL:    rdata = {30'b0, tctrl};
        default:      rdata = '0;
      endcase
    end
  end

  assign bus_rdata = rdata;
  assign irq       = irq_q;

endmodule

// File: tb/tb_irq_controller.sv
// Scoreboarded bench for irq_controller: directed register-map scenarios
// followed by randomized bus/source traffic against a register-level model.
module tb_irq_controller;

  localparam int unsigned N_SRC = 8;
  localparam int unsigned NP    = N_SRC + 1;
  localparam logic [31:0] BASE  = 32'hFFFF_0000;
  localparam logic [31:0] VALID = 32'((64'd1 << NP) - 64'd1);

  logic             clk = 1'b0;
  logic             reset;
  logic [N_SRC-1:0] src_irq;
  logic [31:0]      bus_addr;
  logic [31:0]      bus_wdata;
  logic             bus_wr;
  logic [15:0]      bus_wr_mask;
  logic             bus_sel;
  logic [31:0]      bus_rdata;
  logic             irq;

  always #5 clk = ~clk;

  irq_controller #(.N_SRC(N_SRC), .BASE_ADDR(BASE)) dut (
    .clk         (clk),
    .reset       (reset),
    .src_irq     (src_irq),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_wr      (bus_wr),
    .bus_wr_mask (bus_wr_mask),
    .bus_sel     (bus_sel),
    .bus_rdata   (bus_rdata),
    .irq         (irq)
  );

  typedef struct {
    string       name;
    bit          is_read;
    logic [31:0] rdata;
    logic        sel;
    logic        irq;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Reference state, kept as plain register values
  logic [31:0]      m_pend   = '0;
  logic [31:0]      m_en     = '0;
  logic [31:0]      m_tcnt   = '0;
  logic [31:0]      m_tcmp   = '0;
  int unsigned      m_active = 0;
  bit               m_ten    = 0;
  bit               m_trel   = 0;
  bit               m_irq    = 0;
  logic [N_SRC-1:0] m_src    = '0;
  logic [N_SRC-1:0] src_lvl  = '0;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endfunction

  function automatic logic [31:0] bytes_of(input logic [15:0] mask);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) if (mask[b]) m = m | (32'hFF << (8 * b));
    return m;
  endfunction

  function automatic bit in_window(input logic [31:0] a);
    return (a >= BASE) && (a <= BASE + 32'h3F);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] o;
    if (!in_window(a)) return '0;
    o = (a - BASE) & 32'h3C;
    case (o)
      32'h00: return m_pend;
      32'h04: return m_en;
      32'h08: begin
        for (int k = 0; k < NP; k++) if (m_pend[k] && m_en[k]) return 32'(k + 1);
        return '0;
      end
      32'h0C: return m_active;
      32'h10: return m_tcnt;
      32'h14: return m_tcmp;
      32'h18: return {30'b0, m_trel, m_ten};
      default: return '0;
    endcase
  endfunction

  task automatic model_step(input bit rst, input bit wr, input logic [31:0] a,
                            input logic [31:0] wd, input logic [15:0] mask,
                            input logic [N_SRC-1:0] src);
    bit          we, hit, nirq;
    logic [31:0] o, bm, np, nt;
    if (!rst) begin
      m_pend = '0; m_en = '0; m_tcnt = '0; m_tcmp = '0; m_active = 0;
      m_ten = 0; m_trel = 0; m_irq = 0; m_src = '0;
      return;
    end
    we   = wr && in_window(a);
    o    = (a - BASE) & 32'h3C;
    bm   = bytes_of(mask);
    hit  = m_ten && (m_tcnt == m_tcmp);
    nirq = ((m_pend & m_en) != 0) && (m_active == 0);

    np = m_pend;
    if (we && o == 32'h00) np = np & ~(wd & bm);
    if (we && o == 32'h08 && wd >= 1 && wd <= NP) begin
      np = np & ~(32'd1 << (wd - 1));
      m_active = wd;
    end
    if (we && o == 32'h0C) m_active = 0;
    np = np | (32'(src & ~m_src) << 1) | 32'(hit);
    m_pend = np & VALID;

    if (we && o == 32'h04) m_en = ((m_en & ~bm) | (wd & bm)) & VALID;

    nt = m_tcnt;
    if (m_ten) nt = (hit && m_trel) ? 32'd0 : m_tcnt + 32'd1;
    if (we && o == 32'h10) nt = (m_tcnt & ~bm) | (wd & bm);
    m_tcnt = nt;
    if (we && o == 32'h14) m_tcmp = (m_tcmp & ~bm) | (wd & bm);
    if (we && o == 32'h18 && mask[0]) begin
      m_ten  = wd[0];
      m_trel = wd[1];
    end

    m_src = src;
    m_irq = nirq;
  endtask

  task automatic cyc(input string name, input bit rst, input bit wr, input logic [31:0] a,
                     input logic [31:0] wd, input logic [15:0] mask);
    exp_t e;
    reset = rst; bus_wr = wr; bus_addr = a; bus_wdata = wd; bus_wr_mask = mask;
    src_irq = src_lvl;
    e.name    = name;
    e.is_read = !wr;
    e.rdata   = model_read(a);
    e.sel     = in_window(a);
    e.irq     = m_irq;
    sb.push_back(e);
    @(posedge clk);
    model_step(rst, wr, a, wd, mask, src_lvl);
    #1;
  endtask

  task automatic rd(input string name, input logic [5:0] off);
    cyc(name, 1'b1, 1'b0, BASE + 32'(off), 32'h0, 16'h0);
  endtask

  task automatic wr(input string name, input logic [5:0] off, input logic [31:0] d,
                    input logic [15:0] mask = 16'h000F);
    cyc(name, 1'b1, 1'b1, BASE + 32'(off), d, mask);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({e.name, "/irq"}, {31'b0, irq}, {31'b0, e.irq});
      check({e.name, "/sel"}, {31'b0, bus_sel}, {31'b0, e.sel});
      if (e.is_read) check({e.name, "/rdata"}, bus_rdata, e.rdata);
    end
  end

  initial begin
    logic [31:0] a, d;
    logic [15:0] mk;
    int unsigned o;
    bit          w, r;

    reset = 1'b0; bus_wr = 1'b0; bus_addr = '0; bus_wdata = '0;
    bus_wr_mask = '0; src_irq = '0;
    @(posedge clk); #1;

    src_lvl = '1;
    cyc("rst_hold0", 1'b0, 1'b0, BASE, 32'h0, 16'h0);
    cyc("rst_hold1", 1'b0, 1'b0, BASE + 32'h4, 32'h0, 16'h0);
    src_lvl = '0;
    rd("rst_pending", 6'h00);
    rd("rst_enable", 6'h04);
    rd("rst_claim", 6'h08);

    wr("en_6", 6'h04, 32'h6);
    src_lvl = 8'h01;
    rd("claim_t0", 6'h08);
    src_lvl = '0;
    rd("claim_t1", 6'h08);
    rd("claim_t2", 6'h08);
    wr("claim_2", 6'h08, 32'd2);
    rd("pend_after_claim", 6'h00);
    rd("active_2", 6'h0C);
    rd("irq_masked", 6'h08);
    wr("complete", 6'h0C, 32'h0);
    rd("active_0", 6'h0C);

    wr("en_a", 6'h04, 32'hA);
    src_lvl = 8'h05;
    rd("prio_t0", 6'h08);
    src_lvl = '0;
    rd("prio_claim2", 6'h08);
    wr("claim_src1", 6'h08, 32'd2);
    rd("prio_claim4", 6'h08);
    wr("claim_oor", 6'h08, 32'd40);
    rd("active_kept", 6'h0C);
    cyc("rst_mid_claim", 1'b0, 1'b0, BASE + 32'hC, 32'h0, 16'h0);
    rd("active_after_rst", 6'h0C);

    wr("t_en", 6'h04, 32'h1);
    wr("t_cmp", 6'h14, 32'd5);
    wr("t_ctrl", 6'h18, 32'h3);
    for (int i = 0; i < 10; i++) rd("tcnt_reload", 6'h10);
    rd("t_pending", 6'h00);
    rd("t_claim", 6'h08);
    wr("t_norel", 6'h18, 32'h1);
    wr("t_max", 6'h10, 32'hFFFF_FFFF);
    rd("tcnt_wrap0", 6'h10);
    rd("tcnt_wrap1", 6'h10);
    rd("tctrl_rd", 6'h18);
    wr("t_off", 6'h18, 32'h0);
    wr("w1c_all", 6'h00, 32'hFFFF_FFFF);

    wr("en_mask", 6'h04, 32'hFFFF_FFFF, 16'h0002);
    rd("en_masked", 6'h04);

    wr("en_2", 6'h04, 32'h2);
    src_lvl = 8'h01;
    wr("w1c_coll", 6'h00, 32'h2);
    src_lvl = '0;
    rd("coll_pending", 6'h00);

    rd("unmapped", 6'h1C);
    cyc("below_win", 1'b1, 1'b0, BASE - 32'h4, 32'h0, 16'h0);
    cyc("above_win", 1'b1, 1'b0, BASE + 32'h40, 32'h0, 16'h0);
    cyc("wr_outside", 1'b1, 1'b1, BASE + 32'h44, 32'hFF, 16'hF);
    rd("en_unchanged", 6'h04);

    for (int i = 0; i < 800; i++) begin
      o  = $urandom_range(0, 15) * 4;
      a  = ($urandom_range(0, 9) == 0) ? $urandom : BASE + o;
      w  = ($urandom_range(0, 9) < 4);
      r  = ($urandom_range(0, 99) != 0);
      mk = ($urandom_range(0, 9) < 7) ? 16'h000F : 16'($urandom);
      case (o)
        8:       d = $urandom_range(0, NP + 2);
        16, 20:  d = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 40);
        24:      d = $urandom_range(0, 3);
        default: d = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) src_lvl = src_lvl ^ N_SRC'($urandom);
      cyc("rand", r, w, a, d, mk);
    end

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    check("drain", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
